// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the memory port arbiter.
//   addr_t / op_t  - datapath address and data words
//   arb_state_t    - transaction FSM states
//   requester_t    - requester identity (instruction fetch or data)
//   starve_cnt_t   - width of the IF starvation counter
//   ReadLatencyMax / MaxStarveLimit - largest legal parameter values
package mem_port_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] op_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } arb_state_t;

    typedef enum logic {
        ReqIf = 1'b0,
        ReqD  = 1'b1
    } requester_t;

    typedef logic [3:0] starve_cnt_t;

    localparam int unsigned ReadLatencyMax = 3;
    localparam int unsigned MaxStarveLimit = 15;

endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: winner select and IF starvation counter.
//   clk, rst  - clock, synchronous active-high reset
//   if_valid  - IF request valid
//   d_valid   - D request valid
//   grant_en  - arbitration is open this cycle (arbiter idle)
//   winner    - selected requester, requester_t encoding (0 = IF, 1 = D)
//   grant     - a request is accepted this cycle (grant_en and any valid)
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic d_valid,
    input  logic grant_en,
    output logic winner,
    output logic grant
);

    localparam int unsigned MaxStarveEff =
        (MAX_STARVE > MaxStarveLimit) ? MaxStarveLimit : MAX_STARVE;
    localparam starve_cnt_t StarveCap = starve_cnt_t'(MaxStarveEff);

    starve_cnt_t starve_q, starve_d;
    logic        force_if;
    requester_t  win_sel;

    // A cap of zero disables forcing: data keeps strict priority.
    always_comb begin
        force_if = (StarveCap != '0) && (starve_q == StarveCap);
        if (d_valid && !(if_valid && force_if)) begin
            win_sel = ReqD;
        end else begin
            win_sel = ReqIf;
        end
    end

    assign winner = win_sel;
    assign grant  = grant_en && (if_valid || d_valid);

    // Counts only accepted D grants that left a waiting IF behind.
    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if (win_sel == ReqIf) begin
                starve_d = '0;
            end else if (if_valid && (starve_q < StarveCap)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and data load/store (D). One transaction in flight: IDLE -> ACCESS -> RESP.
// Data wins arbitration unless IF has lost MAX_STARVE times in a row.
//
// Parameters:
//   READ_LATENCY - cycles from mem_addr to valid mem_rdata (0..3)
//   MAX_STARVE   - IF losses before IF is forced to win, 0 = strict D priority (0..15)
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   if_req_valid/addr/ready       - IF read request handshake
//   if_resp_valid/data            - IF response pulse and registered read data
//   d_req_valid/write/addr/wdata  - D request (write=1 store, 0 load)
//   d_req_ready                   - D request accepted
//   d_resp_valid/data             - D response pulse, data 0 for stores
//   mem_addr/write/wdata/rdata    - memory port
//   busy                          - transaction in flight
// Optional build macro MEM_ARB_PERF_EN adds saturating counters
//   perf_if_grants, perf_d_grants, perf_conflicts (IDLE cycles with both valid).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned MAX_STARVE   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        d_req_valid,
    input  logic        d_req_write,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
`endif
);

    localparam int unsigned ReadLatencyEff =
        (READ_LATENCY > ReadLatencyMax) ? ReadLatencyMax : READ_LATENCY;
    localparam logic [1:0] LatLoad = 2'(ReadLatencyEff);

    arb_state_t state_q, state_d;
    requester_t owner_q, owner_d;
    addr_t      addr_q, addr_d;
    logic       write_q, write_d;
    op_t        wdata_q, wdata_d;
    logic [1:0] lat_q, lat_d;
    op_t        if_data_q, if_data_d;
    op_t        d_data_q, d_data_d;

    logic       idle;
    logic       winner;
    logic       grant;
    requester_t winner_req;

    assign idle = (state_q == StIdle);

    mem_arb_priority #(
        .MAX_STARVE(MAX_STARVE)
    ) u_priority (
        .clk     (clk),
        .rst     (rst),
        .if_valid(if_req_valid),
        .d_valid (d_req_valid),
        .grant_en(idle),
        .winner  (winner),
        .grant   (grant)
    );

    assign winner_req = requester_t'(winner);

    // grant already implies the arbiter is idle and the winner is valid.
    assign if_req_ready = grant && (winner_req == ReqIf) && if_req_valid;
    assign d_req_ready  = grant && (winner_req == ReqD) && d_req_valid;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        if_data_d = if_data_q;
        d_data_d  = d_data_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAccess;
                    owner_d = winner_req;
                    if (winner_req == ReqD) begin
                        addr_d  = d_req_addr;
                        write_d = d_req_write;
                        wdata_d = d_req_wdata;
                        lat_d   = d_req_write ? 2'd0 : LatLoad;
                    end else begin
                        addr_d  = if_req_addr;
                        write_d = 1'b0;
                        wdata_d = '0;
                        lat_d   = LatLoad;
                    end
                end
            end
            StAccess: begin
                // Last access cycle: rdata is valid now, capture it for the owner.
                if (lat_q == 2'd0) begin
                    state_d = StResp;
                    if (owner_q == ReqIf) begin
                        if_data_d = mem_rdata;
                    end else begin
                        d_data_d = write_q ? '0 : mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= ReqIf;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            lat_q     <= 2'd0;
            if_data_q <= '0;
            d_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            lat_q     <= lat_d;
            if_data_q <= if_data_d;
            d_data_q  <= d_data_d;
        end
    end

    // addr_q only changes on a handshake, so mem_addr holds between accesses.
    assign mem_addr      = addr_q;
    assign mem_write     = (state_q == StAccess) && write_q;
    assign mem_wdata     = wdata_q;
    assign if_resp_valid = (state_q == StResp) && (owner_q == ReqIf);
    assign d_resp_valid  = (state_q == StResp) && (owner_q == ReqD);
    assign if_resp_data  = if_data_q;
    assign d_resp_data   = d_data_q;
    assign busy          = !idle;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_d_q, perf_conf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q   <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            if (if_req_ready && (perf_if_q != '1)) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (d_req_ready && (perf_d_q != '1)) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
            if (idle && if_req_valid && d_req_valid && (perf_conf_q != '1)) begin
                perf_conf_q <= perf_conf_q + 32'd1;
            end
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_conf_q;
`endif

endmodule
